aemb_ifetch: RTL

- Instruction fetch and prefetch stage, directly upstream of the instruction buffer/decode stage.
- Generates the fetch program counter and runs classic Wishbone reads on the instruction bus, one outstanding cycle at a time.
- Holds fetched words with their PCs in a small FIFO and presents the head word to the instruction buffer.
- Flushes and redirects on taken branches.

---
 rtl/aemb_pkg.sv | 19 +
 rtl/aemb_sync_fifo.sv | 72 +++++++
 rtl/aemb_ifetch.sv | 134 +++++++++++++
 3 files changed

// File: rtl/aemb_pkg.sv
// Shared constants and types for the aemb fetch front end.
package aemb_pkg;

  localparam int INSN_W     = 32;
  localparam int AW_DEFAULT = 16;

  localparam logic [INSN_W-1:0] NOP_INSN = 32'h8800_0000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } fetch_state_e;

  // Fetch addresses are always word aligned.
  function automatic logic [AW_DEFAULT-1:0] word_align(input logic [AW_DEFAULT-1:0] adr);
    return {adr[AW_DEFAULT-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/aemb_sync_fifo.sv
// Synchronous FIFO with clear; exposes next-cycle count so the fetcher can
// decide whether to keep the bus busy without waiting a cycle.
module aemb_sync_fifo #(
  parameter int WIDTH      = 48,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  gclk,
  input  logic                  grst,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  clear,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata,
  output logic [DEPTH_LOG2:0]   count_next,
  output logic                  empty,
  output logic                  full
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_C = (DEPTH_LOG2+1)'(DEPTH);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  full_q, full_d;
  logic                  do_push, do_pop;

  assign do_pop  = pop & (count_q != '0);
  assign do_push = push & ((count_q != DEPTH_C) | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + (DEPTH_LOG2+1)'(do_push) - (DEPTH_LOG2+1)'(do_pop);
    end
    full_d = (count_d == DEPTH_C);
  end

  always_ff @(posedge gclk or negedge grst) begin
    if (!grst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge gclk) begin
    if (do_push && !clear) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata      = mem_q[rd_ptr_q];
  assign count_next = count_d;
  assign empty      = (count_q == '0);
  assign full       = full_q;

endmodule

// File: rtl/aemb_ifetch.sv
// Instruction fetch/prefetch: PC, single-outstanding Wishbone reads, prefetch FIFO.
// Optional same-cycle bypass of acked data when the FIFO is empty: AEMB_IFETCH_BYPASS_EN.
module aemb_ifetch
  import aemb_pkg::*;
#(
  parameter int            AW         = AW_DEFAULT,
  parameter int            DEPTH_LOG2 = 2,
  parameter logic [AW-1:0] RST_VEC    = '0
) (
  input  logic              gclk,
  input  logic              grst,
  input  logic              gena,
  input  logic              rBRA,
  input  logic [AW-1:0]     xBRA_ADR,
  output logic [AW-1:0]     iwb_adr_o,
  output logic              iwb_stb_o,
  input  logic              iwb_ack_i,
  input  logic [31:0]       iwb_dat_i,
  output logic [31:0]       xIDAT,
  output logic [AW-1:0]     xIPC,
  output logic              xIVLD,
  output logic              rFULL
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_C = (DEPTH_LOG2+1)'(DEPTH);
  localparam int FW = INSN_W + AW;

  fetch_state_e  state_q, state_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          drop_q, drop_d;

  logic                ack, take;
  logic                byp_vld, byp_use;
  logic                fifo_push, fifo_pop;
  logic [FW-1:0]       fifo_rdata;
  logic [DEPTH_LOG2:0] fifo_count_next;
  logic                fifo_empty, fifo_full;
  logic [INSN_W-1:0]   head_dat;
  logic [AW-1:0]       head_pc;

  assign ack  = (state_q == ST_REQ) & iwb_ack_i;
  assign take = ack & ~drop_q & ~rBRA;

`ifdef AEMB_IFETCH_BYPASS_EN
  assign byp_vld = take & fifo_empty;
  assign byp_use = byp_vld & gena;
`else
  assign byp_vld = 1'b0;
  assign byp_use = 1'b0;
`endif

  assign fifo_push = take & ~byp_use;
  assign fifo_pop  = gena & ~rBRA;

  aemb_sync_fifo #(
    .WIDTH      (FW),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .gclk       (gclk),
    .grst       (grst),
    .push       (fifo_push),
    .pop        (fifo_pop),
    .clear      (rBRA),
    .wdata      ({iwb_dat_i, pc_q}),
    .rdata      (fifo_rdata),
    .count_next (fifo_count_next),
    .empty      (fifo_empty),
    .full       (fifo_full)
  );

  assign head_dat = fifo_rdata[FW-1:AW];
  assign head_pc  = fifo_rdata[AW-1:0];

  // An outstanding cycle is never abandoned; a flush only marks its data for discard.
  always_comb begin
    pc_d = pc_q;
    if (rBRA)
      pc_d = {xBRA_ADR[AW-1:2], 2'b00};
    else if (ack && !drop_q)
      pc_d = pc_q + AW'(4);

    drop_d = drop_q;
    if (ack)
      drop_d = 1'b0;
    else if (rBRA && state_q == ST_REQ)
      drop_d = 1'b1;

    state_d = state_q;
    adr_d   = adr_q;
    if (state_q == ST_REQ && !ack) begin
      state_d = ST_REQ;
    end else begin
      state_d = (fifo_count_next < DEPTH_C) ? ST_REQ : ST_IDLE;
      adr_d   = pc_d;
    end
  end

  always_ff @(posedge gclk or negedge grst) begin
    if (!grst) begin
      state_q <= ST_IDLE;
      adr_q   <= RST_VEC;
      pc_q    <= RST_VEC;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
    end
  end

  assign iwb_stb_o = (state_q == ST_REQ);
  assign iwb_adr_o = adr_q;

  always_comb begin
    xIVLD = 1'b0;
    xIDAT = NOP_INSN;
    xIPC  = '0;
    if (byp_vld) begin
      xIVLD = 1'b1;
      xIDAT = iwb_dat_i;
      xIPC  = pc_q;
    end else if (!fifo_empty) begin
      xIVLD = 1'b1;
      xIDAT = head_dat;
      xIPC  = head_pc;
    end
  end

  assign rFULL = fifo_full;

endmodule
